// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-stage load/store access unit with req/ready/rvalid bus
//
// Purpose: takes a decoded load or store from EX/MEM, formats store data and
// byte enables, runs one data-memory bus transaction, stalls the pipeline while
// it is outstanding and returns the sign/zero-extended load result.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mem_en, MemRW, funct3    access request, 1=store, size/sign
//   addr, wdata              effective address, store data
//   stall, fault, bus_err    pipeline freeze, illegal-access pulse, timeout pulse
//   dataR_out                formatted load data for MEM/WB
//   dmem_req/we/addr/wdata/be   bus request side
//   dmem_ready/rvalid/rdata     bus response side

module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        MemRW,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_err,
    output logic [31:0] dataR_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lane_q, lane_d;
    logic          berr_q, berr_d;
    logic [31:0]   data_q, data_d;
    logic          we_q, we_d;
    logic [31:0]   baddr_q, baddr_d;
    logic [31:0]   bwdata_q, bwdata_d;
    logic [3:0]    be_q, be_d;

    logic          illegal;
    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic [31:0]   ld_data;

    // Illegal encodings and misaligned halfword/word accesses.
    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'd3, 3'd6, 3'd7: illegal = 1'b1;
            default:          illegal = 1'b0;
        endcase
        if (funct3[1:0] == 2'b01 && addr[0])
            illegal = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
    end

    // Store lane replication; loads always enable the full word.
    always_comb begin
        st_wdata = wdata;
        st_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{wdata[7:0]}};
                st_be    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{wdata[15:0]}};
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = wdata;
                st_be    = 4'b1111;
            end
        endcase
        if (!MemRW)
            st_be = 4'b1111;
    end

    // Load extraction uses the lane latched at request time, not the live addr.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (lane_q)
            2'd0:    b = dmem_rdata[7:0];
            2'd1:    b = dmem_rdata[15:8];
            2'd2:    b = dmem_rdata[23:16];
            default: b = dmem_rdata[31:24];
        endcase
        h = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'd0:    ld_data = {{24{b[7]}}, b};
            3'd1:    ld_data = {{16{h[15]}}, h};
            3'd4:    ld_data = {24'b0, b};
            3'd5:    ld_data = {16'b0, h};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        lane_d   = lane_q;
        berr_d   = berr_q;
        data_d   = data_q;
        we_d     = we_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        be_d     = be_q;
        case (state_q)
            S_IDLE: begin
                berr_d = 1'b0;
                if (mem_en) begin
                    if (illegal) begin
                        data_d = 32'b0;
                    end else begin
                        f3_d     = funct3;
                        lane_d   = addr[1:0];
                        we_d     = MemRW;
                        baddr_d  = {addr[31:2], 2'b00};
                        bwdata_d = st_wdata;
                        be_d     = st_be;
                        cnt_d    = '0;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Ready is checked first so it wins over a simultaneous timeout.
                if (dmem_ready) begin
                    state_d = we_q ? S_DONE : S_RESP;
                    cnt_d   = cnt_q + 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                    if (!we_q)
                        data_d = 32'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (dmem_rvalid) begin
                    data_d  = ld_data;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                    data_d  = 32'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                berr_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= 3'b0;
            lane_q   <= 2'b0;
            berr_q   <= 1'b0;
            data_q   <= 32'b0;
            we_q     <= 1'b0;
            baddr_q  <= 32'b0;
            bwdata_q <= 32'b0;
            be_q     <= 4'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            lane_q   <= lane_d;
            berr_q   <= berr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            be_q     <= be_d;
        end
    end

    // The IDLE terms look at live inputs, so gate them with rst to keep
    // stall/fault low during reset.
    assign stall      = rst & (((state_q == S_IDLE) & mem_en & ~illegal)
                               | (state_q == S_REQ) | (state_q == S_RESP));
    assign fault      = rst & (state_q == S_IDLE) & mem_en & illegal;
    assign bus_err    = berr_q;
    assign dataR_out  = data_q;
    assign dmem_req   = (state_q == S_REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = baddr_q;
    assign dmem_wdata = bwdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access

module tb_mem_access;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic        MemRW = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall, fault, bus_err;
    logic [31:0] dataR_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        int          stall_n;
        int          fault_n;
        int          berr_n;
        int          req_n;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    int          req_first, berr_at;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .MemRW(MemRW), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .fault(fault), .bus_err(bus_err),
        .dataR_out(dataR_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one op with a bus responder and scores it against the expectation
    // pushed at issue time. rdy_dly >= TO means the bus never accepts.
    task automatic issue(input string tag, input bit rw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int rdy_dly, input int rv_dly, input bit bad,
                         input logic [31:0] exp_data);
        exp_t e, got;
        int   req_cnt = 0;
        int   resp_cnt = 0;
        int   cyc = 0;
        bit   acc = 0;
        bit   fin = 0;
        e.tag = tag;
        e.data = exp_data;
        e.fault_n = bad ? 1 : 0;
        if (bad) begin
            e.stall_n = 0; e.berr_n = 0; e.req_n = 0;
        end else if (rdy_dly >= TO) begin
            e.stall_n = 1 + TO; e.berr_n = 1; e.req_n = TO;
        end else begin
            e.stall_n = 1 + (rdy_dly + 1) + (rw ? 0 : rv_dly + 1);
            e.berr_n = 0; e.req_n = rdy_dly + 1;
        end
        sb_q.push_back(e);
        got.tag = tag; got.data = 32'h0;
        got.stall_n = 0; got.fault_n = 0; got.berr_n = 0; got.req_n = 0;
        req_first = -1; berr_at = -1;
        while (!fin && cyc < 60) begin
            @(negedge clk);
            dmem_rdata  = rd;
            dmem_rvalid = acc && !rw && (resp_cnt == rv_dly);
            if (acc) resp_cnt++;
            dmem_ready = dmem_req && !acc && (req_cnt == rdy_dly);
            if (dmem_ready) acc = 1;
            if (dmem_req) req_cnt++;
            mem_en = 1'b1; MemRW = rw; funct3 = f3; addr = a; wdata = wd;
            #1;
            if (stall) got.stall_n++;
            if (fault) got.fault_n++;
            if (bus_err) begin got.berr_n++; berr_at = cyc; end
            if (dmem_req) begin
                got.req_n++;
                if (req_first < 0) begin
                    req_first = cyc;
                    cap_addr = dmem_addr; cap_wdata = dmem_wdata;
                    cap_be = dmem_be; cap_we = dmem_we;
                end
            end
            if (!stall) fin = 1;
            cyc++;
        end
        chk($sformatf("%s.bound", tag), {31'b0, fin}, 32'd1);
        @(negedge clk);
        mem_en = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        #1;
        if (dmem_req) got.req_n++;
        got.data = dataR_out;
        e = sb_q.pop_front();
        chk($sformatf("%s.data", e.tag), got.data, e.data);
        chk($sformatf("%s.stall_cycles", e.tag), got.stall_n, e.stall_n);
        chk($sformatf("%s.fault", e.tag), got.fault_n, e.fault_n);
        chk($sformatf("%s.bus_err", e.tag), got.berr_n, e.berr_n);
        chk($sformatf("%s.req_cycles", e.tag), got.req_n, e.req_n);
    endtask

    initial begin
        // Reset with a legal op pending: everything must stay quiet.
        mem_en = 1'b1; funct3 = 3'd2; addr = 32'h40;
        #3;
        chk("rst.stall", {31'b0, stall}, 32'd0);
        chk("rst.fault", {31'b0, fault}, 32'd0);
        chk("rst.req", {31'b0, dmem_req}, 32'd0);
        chk("rst.data", dataR_out, 32'h0);
        chk("rst.be", {28'b0, dmem_be}, 32'h0);
        @(negedge clk);
        mem_en = 1'b0; rst = 1'b1;

        issue("lb",  0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, 32'hFFFF_FF80);
        issue("lbu", 0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, 32'h0000_0080);
        issue("lh",  0, 3'd1, 32'h102, 32'h0, 32'h80FF_1234, 1, 1, 0, 32'hFFFF_80FF);
        issue("lhu", 0, 3'd5, 32'h102, 32'h0, 32'h80FF_1234, 0, 2, 0, 32'h0000_80FF);

        issue("sh",  1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0, 0, 32'h0000_80FF);
        chk("sh.addr", cap_addr, 32'h200);
        chk("sh.wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh.be", {28'b0, cap_be}, 32'hC);
        chk("sh.we", {31'b0, cap_we}, 32'd1);

        issue("sb",  1, 3'd0, 32'h301, 32'h1234_5655, 32'h0, 2, 0, 0, 32'h0000_80FF);
        chk("sb.addr", cap_addr, 32'h300);
        chk("sb.wdata", cap_wdata, 32'h5555_5555);
        chk("sb.be", {28'b0, cap_be}, 32'h2);

        issue("lw_mis", 0, 3'd2, 32'h001, 32'h0, 32'h0, 0, 0, 1, 32'h0);
        issue("lw_mid", 0, 3'd2, 32'h408, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 32'hCAFE_F00D);
        issue("f3_3",   0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0, 1, 32'h0);
        issue("lh_mis", 0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0, 1, 32'h0);

        issue("lw_wait", 0, 3'd2, 32'h404, 32'h0, 32'hDEAD_BEEF, 3, 2, 0, 32'hDEAD_BEEF);
        chk("lw_wait.addr", cap_addr, 32'h404);
        chk("lw_wait.be", {28'b0, cap_be}, 32'hF);
        chk("lw_wait.we", {31'b0, cap_we}, 32'd0);

        issue("tmo", 0, 3'd2, 32'h500, 32'h0, 32'h1111_1111, 1000, 0, 0, 32'h0);
        chk("tmo.berr_delay", berr_at - req_first, TO);

        issue("lw", 0, 3'd2, 32'h600, 32'h0, 32'h1234_5678, 0, 0, 0, 32'h1234_5678);

        // Asynchronous reset while a load sits in RESP.
        @(negedge clk);
        mem_en = 1'b1; MemRW = 1'b0; funct3 = 3'd2; addr = 32'h700;
        @(negedge clk);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        chk("arst.pre_stall", {31'b0, stall}, 32'd1);
        chk("arst.pre_req", {31'b0, dmem_req}, 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("arst.stall", {31'b0, stall}, 32'd0);
        chk("arst.data", dataR_out, 32'h0);
        chk("arst.addr", dmem_addr, 32'h0);
        chk("arst.we_be", {27'b0, dmem_we, dmem_be}, 32'h0);
        @(negedge clk);
        mem_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        dmem_rdata = 32'h5A5A_5A5A; dmem_rvalid = 1'b1;
        #1;
        chk("arst.req_after", {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk("arst.data_after", dataR_out, 32'h0);
        chk("arst.stall_after", {31'b0, stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
